// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: ALU opcode constants, shift-op encoding and FSM state type
// for the variable-amount shift sequencer.
// Optional feature macro: SHIFT_SEQ_SRA_EN (enables arithmetic right shift).
package shift_seq_pkg;

  localparam logic [5:0] CTRL_IDLE = 6'h3F;

  localparam logic [5:0] CTRL_SLL1 = 6'h0A;
  localparam logic [5:0] CTRL_SLL2 = 6'h0B;
  localparam logic [5:0] CTRL_SLL8 = 6'h0C;
  localparam logic [5:0] CTRL_SRL1 = 6'h0D;
  localparam logic [5:0] CTRL_SRL2 = 6'h0E;
  localparam logic [5:0] CTRL_SRL8 = 6'h0F;
  localparam logic [5:0] CTRL_SRA1 = 6'h10;
  localparam logic [5:0] CTRL_SRA2 = 6'h11;
  localparam logic [5:0] CTRL_SRA8 = 6'h12;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // SRA is only a legal request when the arithmetic-shift build option is on.
  function automatic logic op_supported(input logic [1:0] op);
`ifdef SHIFT_SEQ_SRA_EN
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`else
    return (op == OP_SLL) || (op == OP_SRL);
`endif
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: request/response and ALU-side signals of the shift sequencer.
// master = requester plus ALU, slave = the sequencer itself.
interface shift_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amount;
  logic [31:0] operand;
  logic [31:0] alu_r;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  modport master (
    output start, op, amount, operand, alu_r,
    input  alu_ctrl, alu_b, busy, done, err, result
  );

  modport slave (
    input  start, op, amount, operand, alu_r,
    output alu_ctrl, alu_b, busy, done, err, result
  );
endinterface

// File: rtl/shift_seq_step.sv
// shift_seq_step: combinational step selector. Picks the largest fixed ALU
// shift (8, 2 or 1) that does not exceed the remaining distance and maps it
// to the ALU opcode for the current operation.
// Optional feature macro: SHIFT_SEQ_SRA_EN.
module shift_seq_step
  import shift_seq_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [4:0] i_rem,
  output logic [5:0] o_alu_ctrl,
  output logic [4:0] o_step
);

  logic w_big;
  logic w_mid;

  assign w_big = (i_rem >= 5'd8);
  assign w_mid = (i_rem >= 5'd2);

  // Greedy step size and matching opcode; unsupported ops fall back to idle.
  always_comb begin
    o_step     = 5'd1;
    o_alu_ctrl = CTRL_IDLE;
    if (w_big) begin
      o_step = 5'd8;
    end else if (w_mid) begin
      o_step = 5'd2;
    end
    case (i_op)
      OP_SLL:  o_alu_ctrl = w_big ? CTRL_SLL8 : (w_mid ? CTRL_SLL2 : CTRL_SLL1);
      OP_SRL:  o_alu_ctrl = w_big ? CTRL_SRL8 : (w_mid ? CTRL_SRL2 : CTRL_SRL1);
`ifdef SHIFT_SEQ_SRA_EN
      OP_SRA:  o_alu_ctrl = w_big ? CTRL_SRA8 : (w_mid ? CTRL_SRA2 : CTRL_SRA1);
`endif
      default: o_alu_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: turns one 0..31-bit shift request into a sequence of fixed
// 1/2/8-bit ALU shift operations, feeding each ALU result back until the
// requested distance is applied. Owns the ALU only while busy.
// Optional feature macro: SHIFT_SEQ_SRA_EN (op=2 arithmetic right shift).
//
// state    | meaning
// ST_IDLE  | waiting for start; ALU released (idle opcode, b=0)
// ST_SHIFT | one ALU step per cycle until the remaining distance is zero
// ST_DONE  | one-cycle done pulse; result and err valid
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter logic [5:0] IDLE_CTRL = CTRL_IDLE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  shift_seq_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic        r_err;
  logic [31:0] r_result;

  logic [5:0]  w_step_ctrl;
  logic [4:0]  w_step;
  logic        w_start_ok;

  shift_seq_step u_step (
    .i_op       (r_op),
    .i_rem      (r_rem),
    .o_alu_ctrl (w_step_ctrl),
    .o_step     (w_step)
  );

  assign w_start_ok = (bus.amount != 5'd0) && op_supported(bus.op);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; zero-distance and unsupported requests skip SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = w_start_ok ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (r_rem == w_step) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch request, accumulate ALU results, capture result on DONE entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= OP_SLL;
      r_acc    <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            r_acc <= bus.operand;
            r_rem <= bus.amount;
            r_err <= !op_supported(bus.op);
            if (!w_start_ok) r_result <= bus.operand;
          end
        end
        ST_SHIFT: begin
          r_acc <= bus.alu_r;
          r_rem <= r_rem - w_step;
          if (r_rem == w_step) r_result <= bus.alu_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.err      = (r_state == ST_DONE) && r_err;
  assign bus.result   = r_result;
  assign bus.alu_ctrl = (r_state == ST_SHIFT) ? w_step_ctrl : IDLE_CTRL;
  assign bus.alu_b    = (r_state == ST_SHIFT) ? r_acc : 32'd0;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the mMips ALU. The ALU only offers fixed 1-, 2- and 8-bit shift opcodes. This block turns one variable-amount shift request (0–31) into a sequence of those opcodes. It drives the ALU `ctrl`/`b` inputs and feeds each result back until the full amount is applied. It sits between the decode/control stage and the ALU, and owns the ALU only while `busy` is high.

## Interface
- `IDLE_CTRL`, default 6'h3F: ALU `ctrl` value driven when not shifting. It is an invalid opcode, so the ALU result is 0.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request strobe; accepted only in IDLE.
- `op` in 2: 0 = SLL, 1 = SRL, 2 = SRA, 3 = reserved.
- `amount` in 5: shift distance, 0–31.
- `operand` in 32: value to shift.
- `alu_r` in 32: ALU result `r`, combinational from `alu_ctrl`/`alu_b`.
- `alu_ctrl` out 6: to ALU `ctrl`.
- `alu_b` out 32: to ALU `b`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high together with `done` when `op` is unsupported.
- `result` out 32: shifted value. Held from `done` until the next accepted request completes.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with `start`=1:
  - latch `op` into `op_q`, `operand` into `acc`, `amount` into `rem`.
  - next state is SHIFT if `amount`≠0 and `op` is supported, otherwise DONE.
  - if `op` is unsupported, set the `err` flag.
- SHIFT, per cycle, choose the step greedily from `rem`:
  - `rem`≥8 → 8-bit step.
  - else `rem`≥2 → 2-bit step.
  - else → 1-bit step.
- ALU codes per step (1 / 2 / 8 bits): SLL 0xA/0xB/0xC, SRL 0xD/0xE/0xF, SRA 0x10/0x11/0x12.
- SHIFT drives: `alu_b`=`acc`; `alu_ctrl` is combinational from `op_q` and `rem`.
- SHIFT at each edge: `acc`←`alu_r`, `rem`←`rem`−step. When the new `rem`=0, go to DONE.
- DONE:
  - `done`=1 for this cycle only.
  - `result`←`acc` is registered on entry, so it is valid in the DONE cycle.
  - `err` is driven from its flag.
  - next state IDLE.
- Outside SHIFT: `alu_ctrl`=`IDLE_CTRL`, `alu_b`=0.
- `start` outside IDLE is ignored and not queued. The earliest next request is the cycle after DONE.
- Unsupported `op`: `result`=`operand` unchanged, `err`=1, and no ALU step is issued.
- `rem` is 5 bits unsigned. The step never exceeds `rem`, so there is no underflow.

## Timing
- Step count S(N) = ⌊N/8⌋ + ⌊(N mod 8)/2⌋ + (N mod 2); maximum S(31)=7.
- With `start` sampled in cycle k:
  - SHIFT occupies cycles k+1 … k+S.
  - `done` is high in cycle k+S+1.
  - N=0 or an unsupported op gives `done` in cycle k+1.
- `busy` rises in cycle k+1 and falls in cycle k+S+2.
- Reset values, including reset applied mid-operation (takes effect immediately, no edge needed):
  - state IDLE.
  - `acc`, `rem`, `result` = 0; `err` flag cleared.
  - `busy`, `done`, `err` = 0.
  - `alu_ctrl`=`IDLE_CTRL`, `alu_b`=0.
  - The in-flight request is discarded.

## Configuration
- `SHIFT_SEQ_SRA_EN` defined: `op`=2 is supported and uses ALU codes 0x10/0x11/0x12.
- `SHIFT_SEQ_SRA_EN` undefined: `op`=2 is treated like reserved `op`=3, i.e. `err`=1, `result`=`operand`, `done` at k+1, and no SRA code is ever driven.

## Structure
- Package `shift_seq_pkg` holds:
  - ALU ctrl code constants (SLL/SRL/SRA × 1/2/8, and the idle code).
  - `op` encoding constants.
  - the state enum typedef.
- Sub-module `shift_seq_step` is purely combinational: (`op_q`, `rem`) → (`alu_ctrl`, step size). The SRA macro is honoured there and in the supported-op check.

## Test plan
1. SLL, `operand` 0x00000001, `amount` 31 → `alu_ctrl` sequence C,C,C,B,B,B,A; `result` 0x80000000; `done` at k+8; `err`=0.
2. SRA (macro on), 0x80000000, `amount` 9 → codes 0x12, 0x10; `result` 0xFFC00000; `done` at k+3.
3. SRL, 0x12345678, `amount` 0 → no ALU code other than `IDLE_CTRL`; `result` 0x12345678; `done` at k+1.
4. Repeated `start` while busy (SRL 0xF0000000 by 4, then a second request) → second request ignored; `result` 0x0F000000. A new `start` in the cycle after `done` is accepted.
5. `rst` low in cycle k+3 of a 31-bit SLL → all outputs at reset values at once; a following SRL 0x100 by 8 gives 0x1 with `done` at k+2.
6. Macro off, `op`=2 on 0xDEADBEEF → `err`=1, `result` 0xDEADBEEF, `done` at k+1; same response for `op`=3 with the macro on.
